psram_qpi_responder: RTL
========================

// Module: psram_qpi_responder
// PURPOSE
// Synthesizable device-side model of one LY68S3200-class serial PSRAM: the responder for memCtrl's QPI bus.
// Decodes SPI/QPI commands and serves quad write (0x38) and quad fast read (0xEB).
// Backed by an on-chip byte array; two instances emulate banks U7/U9 in FPGA-only and simulation builds.
// PARAMETERS
// ADDR_BITS    12  byte array depth = 2**ADDR_BITS; address bits above ADDR_BITS-1 ignored (aliasing)
// WAIT_CYCLES  6   dummy clocks between last read-address nibble and first read-data nibble (1..15)
// PORTS
// i_clkRAM     in   1          PSRAM serial clock as seen at the device pin (gated; stops between frames)
// reset        in   1          async, active-high
// i_psram_cs   in   1          chip select, active-low
// i_sio        in   4          SIO[3:0] input; SPI mode uses i_sio[0] only
// o_sio        out  4          SIO[3:0] drive value
// o_sio_oe     out  1          1 = drive o_sio onto pins (all 4 bits)
// o_qpi_mode   out  1          1 = device is in QPI mode
// o_cmd_err    out  1          1-cycle pulse: unsupported opcode received
// i_bd_addr    in   ADDR_BITS  backdoor read address (bench only)
// o_bd_data    out  8          combinational mem[i_bd_addr]
// BEHAVIOUR
// - Every register except the array is clocked on posedge i_clkRAM; reset clears them asynchronously.
// - Reset values: state=IDLE, o_sio=0, o_sio_oe=0, o_qpi_mode=0, o_cmd_err=0, rst_en=0; array not cleared.
// - Any posedge with i_psram_cs=1 forces IDLE: nibble/bit counter=0, o_sio_oe=0.
//   This aborts any frame; partial write bytes are dropped.
// - States: IDLE, CMD, ADDR, WR_DATA, RD_WAIT, RD_DATA, IGNORE.
// - IDLE: posedge with cs=0 is the first command edge; this sample is consumed as CMD data.
// - CMD in SPI mode: 8 edges, bit i_sio[0], MSB first.
//   0x35 -> o_qpi_mode=1, then IGNORE.
//   0x66 / 0x99 -> reset handling (see below).
//   Any other opcode -> o_cmd_err pulse, then IGNORE.
// - CMD in QPI mode: 2 edges, high nibble first.
//   0x38 or 0xEB -> ADDR.
//   0xF5 -> o_qpi_mode=0, then IGNORE.
//   0x66 / 0x99 -> reset handling.
//   Any other opcode -> o_cmd_err pulse, then IGNORE.
// - Reset handling: 0x66 sets rst_en. 0x99 with rst_en=1 clears o_qpi_mode.
//   rst_en clears on any frame whose opcode is not 0x66.
// - ADDR: 6 edges, nibbles A[23:20] first. The internal pointer latches A[ADDR_BITS-1:0].
// - WR_DATA: nibble pairs, high nibble first. The byte commits to mem[ptr] at the low-nibble edge.
//   ptr increments and wraps at 2**ADDR_BITS-1 -> 0. Unlimited burst until cs rises.
// - RD_WAIT: let edge N sample the last address nibble.
//   Edges N+1..N+WAIT_CYCLES are dummies; inputs are ignored.
//   At edge N+WAIT_CYCLES: o_sio_oe=1 and o_sio=mem[ptr][7:4].
// - RD_DATA: each following edge alternates o_sio=mem[ptr][3:0], then the next byte's high nibble.
//   ptr increments (with wrap) after the low nibble. The host samples nibble k at edge N+WAIT_CYCLES+1+k.
// - IGNORE: hold until cs rises. o_sio_oe=0.
// - A write and a read of the same byte are never simultaneous, so no bypass is needed.
// - o_bd_data is a read-only backdoor and has no effect on the bus.
// TESTING
// 1. Async reset mid-read (reset=1 while RD_DATA) -> o_sio_oe=0 and o_qpi_mode=0 immediately, before the next clock edge.
// 2. SPI 0x35 on SIO0, cs high -> o_qpi_mode=1.
//    Then QPI 0x38, addr 0x000123, data 0xA5 -> o_bd_data@0x123=0xA5.
// 3. QPI 0xEB, addr 0x000123, 6 dummies -> 4-bit bus samples 0xA then 0x5.
//    Those samples fall on edges 7 and 8 after the last address nibble; o_sio_oe=1 from edge 6.
// 4. Write burst at 0xFFF of 0x11,0x22 (ADDR_BITS=12) -> mem[0xFFF]=0x11 and mem[0x000]=0x22 (wrap).
// 5. QPI 0x38, addr, high nibble only, then cs high -> target byte unchanged; next frame decodes normally.
// 6. QPI 0x12 -> o_cmd_err pulses once; QPI 0x66 then 0x99 -> o_qpi_mode=0; SPI 0x99 alone -> no change.

Source files
------------

// File: rtl/psram_qpi_responder.sv
// psram_qpi_responder
//   Device-side model of one LY68S3200-class serial PSRAM. It answers memCtrl's QPI bus
//   and decodes the SPI/QPI command set: quad write (0x38), quad fast read (0xEB), enter QPI
//   (0x35), exit QPI (0xF5) and reset-enable/reset (0x66/0x99). Storage is an on-chip byte
//   array, and the address aliases above ADDR_BITS.
// Ports
//   i_clkRAM    PSRAM serial clock at the device pin (gated, stops between frames)
//   reset       asynchronous, active-high
//   i_psram_cs  chip select, active-low
//   i_sio       SIO[3:0] sampled input (SPI mode uses bit 0 only)
//   o_sio       SIO[3:0] drive value
//   o_sio_oe    1 = drive o_sio onto all four pins
//   o_qpi_mode  1 = device is in QPI mode
//   o_cmd_err   one-cycle pulse on an unsupported opcode
//   i_bd_addr   backdoor read address
//   o_bd_data   combinational mem[i_bd_addr]
module psram_qpi_responder #(
  parameter int unsigned ADDR_BITS   = 12,
  parameter int unsigned WAIT_CYCLES = 6
) (
  input  logic                 i_clkRAM,
  input  logic                 reset,
  input  logic                 i_psram_cs,
  input  logic [3:0]           i_sio,
  output logic [3:0]           o_sio,
  output logic                 o_sio_oe,
  output logic                 o_qpi_mode,
  output logic                 o_cmd_err,
  input  logic [ADDR_BITS-1:0] i_bd_addr,
  output logic [7:0]           o_bd_data
);

  localparam int unsigned Depth    = 1 << ADDR_BITS;
  localparam logic [3:0]  WaitLast = 4'(WAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle, StCmd, StAddr, StWrData, StRdWait, StRdData, StIgnore
  } state_e;

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [6:0]           cmd_q, cmd_d;
  logic [ADDR_BITS-1:0] ptr_q, ptr_d;
  logic [3:0]           wr_hi_q, wr_hi_d;
  logic                 is_read_q, is_read_d;
  logic [3:0]           sio_q, sio_d;
  logic                 sio_oe_q, sio_oe_d;
  logic                 qpi_q, qpi_d;
  logic                 cmd_err_q, cmd_err_d;
  logic                 rst_en_q, rst_en_d;
  logic                 mem_we;
  logic [7:0]           opcode;
  logic [7:0]           rd_byte;

  logic [7:0] mem_q [Depth];

  assign rd_byte = mem_q[ptr_q];
  // The opcode completes with the current sample; the earlier bits or nibble live in cmd_q.
  assign opcode  = qpi_q ? {cmd_q[3:0], i_sio} : {cmd_q, i_sio[0]};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cmd_d     = cmd_q;
    ptr_d     = ptr_q;
    wr_hi_d   = wr_hi_q;
    is_read_d = is_read_q;
    sio_d     = sio_q;
    sio_oe_d  = sio_oe_q;
    qpi_d     = qpi_q;
    rst_en_d  = rst_en_q;
    cmd_err_d = 1'b0;
    mem_we    = 1'b0;

    if (i_psram_cs) begin
      // A deselected edge aborts any frame; a half-received write byte is simply dropped.
      state_d  = StIdle;
      cnt_d    = 4'd0;
      sio_oe_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // The first selected edge already carries opcode data.
          cmd_d   = qpi_q ? {3'b000, i_sio} : {6'b000000, i_sio[0]};
          cnt_d   = 4'd1;
          state_d = StCmd;
        end
        StCmd: begin
          if ((qpi_q && cnt_q == 4'd1) || (!qpi_q && cnt_q == 4'd7)) begin
            cnt_d    = 4'd0;
            state_d  = StIgnore;
            rst_en_d = (opcode == 8'h66);
            if (qpi_q) begin
              case (opcode)
                8'h38: begin state_d = StAddr; is_read_d = 1'b0; end
                8'hEB: begin state_d = StAddr; is_read_d = 1'b1; end
                8'hF5: qpi_d = 1'b0;
                8'h66: ;
                8'h99: if (rst_en_q) qpi_d = 1'b0;
                default: cmd_err_d = 1'b1;
              endcase
            end else begin
              case (opcode)
                8'h35: qpi_d = 1'b1;
                8'h66: ;
                8'h99: if (rst_en_q) qpi_d = 1'b0;
                default: cmd_err_d = 1'b1;
              endcase
            end
          end else begin
            cmd_d = qpi_q ? {cmd_q[2:0], i_sio} : {cmd_q[5:0], i_sio[0]};
            cnt_d = cnt_q + 4'd1;
          end
        end
        StAddr: begin
          // Shifting all six nibbles through ptr leaves A[ADDR_BITS-1:0]; upper bits alias.
          ptr_d = (ptr_q << 4) | ADDR_BITS'(i_sio);
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd5) begin
            cnt_d   = 4'd0;
            state_d = is_read_q ? StRdWait : StWrData;
          end
        end
        StWrData: begin
          if (!cnt_q[0]) begin
            wr_hi_d = i_sio;
            cnt_d   = 4'd1;
          end else begin
            mem_we = 1'b1;
            ptr_d  = ptr_q + ADDR_BITS'(1);
            cnt_d  = 4'd0;
          end
        end
        StRdWait: begin
          // The last dummy edge already presents the first high nibble.
          if (cnt_q == WaitLast) begin
            sio_oe_d = 1'b1;
            sio_d    = rd_byte[7:4];
            cnt_d    = 4'd0;
            state_d  = StRdData;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        StRdData: begin
          if (!cnt_q[0]) begin
            sio_d = rd_byte[3:0];
            ptr_d = ptr_q + ADDR_BITS'(1);
            cnt_d = 4'd1;
          end else begin
            sio_d = rd_byte[7:4];
            cnt_d = 4'd0;
          end
        end
        StIgnore: sio_oe_d = 1'b0;
        default:  state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge i_clkRAM or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      cmd_q     <= 7'd0;
      ptr_q     <= '0;
      wr_hi_q   <= 4'd0;
      is_read_q <= 1'b0;
      sio_q     <= 4'd0;
      sio_oe_q  <= 1'b0;
      qpi_q     <= 1'b0;
      cmd_err_q <= 1'b0;
      rst_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cmd_q     <= cmd_d;
      ptr_q     <= ptr_d;
      wr_hi_q   <= wr_hi_d;
      is_read_q <= is_read_d;
      sio_q     <= sio_d;
      sio_oe_q  <= sio_oe_d;
      qpi_q     <= qpi_d;
      cmd_err_q <= cmd_err_d;
      rst_en_q  <= rst_en_d;
    end
  end

  // The array has no reset, so its contents survive a device reset.
  always_ff @(posedge i_clkRAM) begin
    if (mem_we) mem_q[ptr_q] <= {wr_hi_q, i_sio};
  end

  assign o_sio      = sio_q;
  assign o_sio_oe   = sio_oe_q;
  assign o_qpi_mode = qpi_q;
  assign o_cmd_err  = cmd_err_q;
  assign o_bd_data  = mem_q[i_bd_addr];

endmodule
